// File: rtl/verirsc_pkg.sv
// Shared definitions for the VeriRISC sequencer.
//   OPCODE_W / PHASE_W : field widths
//   HLT..JMP           : opcode values
//   phase_e            : the eight instruction phases (INST_ADDR..STORE)
//   run_e              : RUNNING / HALTED flag held beside the phase
package verirsc_pkg;

    localparam int OPCODE_W = 3;
    localparam int PHASE_W  = 3;

    localparam logic [OPCODE_W-1:0] HLT = 3'd0;
    localparam logic [OPCODE_W-1:0] SKZ = 3'd1;
    localparam logic [OPCODE_W-1:0] ADD = 3'd2;
    localparam logic [OPCODE_W-1:0] AND = 3'd3;
    localparam logic [OPCODE_W-1:0] XOR = 3'd4;
    localparam logic [OPCODE_W-1:0] LDA = 3'd5;
    localparam logic [OPCODE_W-1:0] STO = 3'd6;
    localparam logic [OPCODE_W-1:0] JMP = 3'd7;

    typedef enum logic [PHASE_W-1:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    typedef enum logic {
        RUNNING = 1'b0,
        HALTED  = 1'b1
    } run_e;

endpackage

// File: rtl/sequence_controller_phase_counter.sv
// Phase/state register of the sequencer: advances one phase per cycle,
// stalls on memory, wraps STORE -> INST_ADDR, and holds the halt flag.
//   clk, rst_n  : clock, async active-low reset
//   mem_ready   : memory read complete
//   resume      : leaves HALTED
//   op_is_alu   : current opcode reads an operand (stalls in OP_FETCH)
//   op_is_hlt   : current opcode is HLT
//   phase       : current phase (0 while halted)
//   halted      : halt flag
//
// state              | meaning
// RUNNING/INST_ADDR  | PC drives address bus
// RUNNING/INST_FETCH | instruction read, waits for mem_ready
// RUNNING/INST_LOAD  | IR loads
// RUNNING/IDLE       | IR holds, bus settles
// RUNNING/OP_ADDR    | PC increments, HLT branches to HALTED
// RUNNING/OP_FETCH   | operand read, waits for mem_ready on ALU ops
// RUNNING/ALU_OP     | ALU op, SKZ skip, JMP/STO set up
// RUNNING/STORE      | AC load, memory write, jump
// HALTED             | stopped until resume
module phase_counter
    import verirsc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mem_ready,
    input  logic               resume,
    input  logic               op_is_alu,
    input  logic               op_is_hlt,
    output logic [PHASE_W-1:0] phase,
    output logic               halted
);

    run_e   run_q,   run_d;
    phase_e phase_q, phase_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= RUNNING;
            phase_q <= INST_ADDR;
        end else begin
            run_q   <= run_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        run_d   = run_q;
        phase_d = phase_q;
        if (run_q == HALTED) begin
            // phase is parked at INST_ADDR so clearing the flag restarts there
            if (resume) run_d = RUNNING;
        end else begin
            case (phase_q)
                INST_FETCH: phase_d = mem_ready ? INST_LOAD : INST_FETCH;
                OP_ADDR: begin
                    if (op_is_hlt) begin
                        run_d   = HALTED;
                        phase_d = INST_ADDR;
                    end else begin
                        phase_d = OP_FETCH;
                    end
                end
                // only opcodes that actually read memory wait here
                OP_FETCH:   phase_d = (op_is_alu && !mem_ready) ? OP_FETCH : ALU_OP;
                default:    phase_d = phase_e'(phase_q + 3'd1);
            endcase
        end
    end

    assign phase  = phase_q;
    assign halted = (run_q == HALTED);

endmodule

// File: rtl/sequence_controller.sv
// VeriRISC instruction sequencer: decodes phase, opcode and zero flag into
// datapath load/enable strobes and memory controls.
//   clk, rst_n          : clock, async active-low reset
//   opcode, zero        : IR opcode field, accumulator-zero flag
//   mem_ready, resume   : memory handshake, halt release
//   sel, rd, wr, data_e : address mux / memory read / write / bus drive
//   ld_ir, ld_ac, ld_pc : register loads; inc_pc : PC increment
//   halt, phase         : halt status, current phase
module sequence_controller
    import verirsc_pkg::*;
#(
    parameter int OPCODE_W = verirsc_pkg::OPCODE_W,
    parameter int PHASE_W  = verirsc_pkg::PHASE_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    input  logic                resume,
    output logic                sel,
    output logic                rd,
    output logic                ld_ir,
    output logic                ld_ac,
    output logic                ld_pc,
    output logic                inc_pc,
    output logic                wr,
    output logic                data_e,
    output logic                halt,
    output logic [PHASE_W-1:0]  phase
);

    logic aluop, is_skz, is_sto, is_jmp, is_hlt, halted;

    assign aluop  = (opcode == ADD) || (opcode == AND) || (opcode == XOR) || (opcode == LDA);
    assign is_skz = (opcode == SKZ);
    assign is_sto = (opcode == STO);
    assign is_jmp = (opcode == JMP);
    assign is_hlt = (opcode == HLT);

    phase_counter u_phase_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_ready (mem_ready),
        .resume    (resume),
        .op_is_alu (aluop),
        .op_is_hlt (is_hlt),
        .phase     (phase),
        .halted    (halted)
    );

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        inc_pc = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = halted;
        if (!halted) begin
            case (phase_e'(phase))
                INST_ADDR:  sel = 1'b1;
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR:    inc_pc = 1'b1;
                OP_FETCH:   rd = aluop;
                ALU_OP: begin
                    rd     = aluop;
                    inc_pc = is_skz && zero;
                    ld_pc  = is_jmp;
                    data_e = is_sto;
                end
                STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    ld_pc  = is_jmp;
                    data_e = is_sto;
                    wr     = is_sto;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sequence_controller.sv
module tb_sequence_controller;
    import verirsc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] opcode;
    logic       zero, mem_ready, resume;
    logic       sel, rd, ld_ir, ld_ac, ld_pc, inc_pc, wr, data_e, halt;
    logic [2:0] phase;

    sequence_controller dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .resume    (resume),
        .sel       (sel),
        .rd        (rd),
        .ld_ir     (ld_ir),
        .ld_ac     (ld_ac),
        .ld_pc     (ld_pc),
        .inc_pc    (inc_pc),
        .wr        (wr),
        .data_e    (data_e),
        .halt      (halt),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    // output vector order: sel rd ld_ir ld_ac ld_pc inc_pc wr data_e halt
    localparam logic [8:0] P0   = 9'b100000000;
    localparam logic [8:0] P1   = 9'b110000000;
    localparam logic [8:0] P23  = 9'b111000000;
    localparam logic [8:0] INC  = 9'b000001000;
    localparam logic [8:0] NONE = 9'b000000000;
    localparam logic [8:0] RD   = 9'b010000000;
    localparam logic [8:0] RDAC = 9'b010100000;
    localparam logic [8:0] LDPC = 9'b000010000;
    localparam logic [8:0] DE   = 9'b000000010;
    localparam logic [8:0] WRDE = 9'b000000110;
    localparam logic [8:0] HLTO = 9'b000000001;

    typedef struct {
        logic [2:0] op;
        logic       z;
        logic       mr;
        logic       res;
        logic [2:0] ph;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [8:0] outs();
        return {sel, rd, ld_ir, ld_ac, ld_pc, inc_pc, wr, data_e, halt};
    endfunction

    task automatic add(input logic [2:0] op, input logic z, input logic mr,
                       input logic res, input logic [2:0] ph, input logic [8:0] exp);
        vec_t v;
        v.op = op; v.z = z; v.mr = mr; v.res = res; v.ph = ph; v.exp = exp;
        vecs.push_back(v);
    endtask

    // phases 0..4 without stalls
    task automatic fetch(input logic [2:0] op, input logic z);
        add(op, z, 1'b1, 1'b0, 3'd0, P0);
        add(op, z, 1'b1, 1'b0, 3'd1, P1);
        add(op, z, 1'b1, 1'b0, 3'd2, P23);
        add(op, z, 1'b1, 1'b0, 3'd3, P23);
        add(op, z, 1'b1, 1'b0, 3'd4, INC);
    endtask

    task automatic check(input string name, input logic [2:0] want_ph, input logic [8:0] want_o);
        checks++;
        if (phase !== want_ph) begin
            errors++;
            $display("FAIL %s phase got %0d want %0d", name, phase, want_ph);
        end
        checks++;
        if (outs() !== want_o) begin
            errors++;
            $display("FAIL %s outputs got %b want %b", name, outs(), want_o);
        end
    endtask

    initial begin
        rst_n = 1'b0; opcode = ADD; zero = 1'b0; mem_ready = 1'b1; resume = 1'b0;

        // ADD
        fetch(ADD, 1'b0);
        add(ADD, 0, 1, 0, 3'd5, RD);
        add(ADD, 0, 1, 0, 3'd6, RD);
        add(ADD, 0, 1, 0, 3'd7, RDAC);
        // STO
        fetch(STO, 1'b0);
        add(STO, 0, 1, 0, 3'd5, NONE);
        add(STO, 0, 1, 0, 3'd6, DE);
        add(STO, 0, 1, 0, 3'd7, WRDE);
        // SKZ, zero set then clear
        fetch(SKZ, 1'b1);
        add(SKZ, 1, 1, 0, 3'd5, NONE);
        add(SKZ, 1, 1, 0, 3'd6, INC);
        add(SKZ, 1, 1, 0, 3'd7, NONE);
        fetch(SKZ, 1'b0);
        add(SKZ, 0, 1, 0, 3'd5, NONE);
        add(SKZ, 0, 1, 0, 3'd6, NONE);
        add(SKZ, 0, 1, 0, 3'd7, NONE);
        // LDA with 3 stall cycles in INST_FETCH and 2 in OP_FETCH: 13 cycles
        add(LDA, 0, 1, 0, 3'd0, P0);
        for (int i = 0; i < 3; i++) add(LDA, 0, 0, 0, 3'd1, P1);
        add(LDA, 0, 1, 0, 3'd1, P1);
        add(LDA, 0, 1, 0, 3'd2, P23);
        add(LDA, 0, 1, 0, 3'd3, P23);
        add(LDA, 0, 1, 0, 3'd4, INC);
        for (int i = 0; i < 2; i++) add(LDA, 0, 0, 0, 3'd5, RD);
        add(LDA, 0, 1, 0, 3'd5, RD);
        add(LDA, 0, 1, 0, 3'd6, RD);
        add(LDA, 0, 1, 0, 3'd7, RDAC);
        // JMP: resume in phase 2 ignored, no stall in OP_FETCH
        add(JMP, 0, 1, 0, 3'd0, P0);
        add(JMP, 0, 1, 0, 3'd1, P1);
        add(JMP, 0, 1, 1, 3'd2, P23);
        add(JMP, 0, 1, 0, 3'd3, P23);
        add(JMP, 0, 1, 0, 3'd4, INC);
        add(JMP, 0, 0, 0, 3'd5, NONE);
        add(JMP, 0, 1, 0, 3'd6, LDPC);
        add(JMP, 0, 1, 0, 3'd7, LDPC);
        // HLT: halted 10 cycles, then resume together with mem_ready
        fetch(HLT, 1'b0);
        for (int i = 0; i < 10; i++) add(HLT, 0, 1'(i % 2), 0, 3'd0, HLTO);
        add(HLT, 0, 1, 1, 3'd0, HLTO);
        // STO restarting from INST_ADDR; never stalls in OP_FETCH
        fetch(STO, 1'b0);
        add(STO, 0, 0, 0, 3'd5, NONE);

        // reset state
        #1;
        check("reset", 3'd0, P0);
        @(posedge clk); @(posedge clk);
        #1;
        check("reset_held", 3'd0, P0);

        @(negedge clk);
        rst_n = 1'b1;
        foreach (vecs[i]) begin
            opcode    = vecs[i].op;
            zero      = vecs[i].z;
            mem_ready = vecs[i].mr;
            resume    = vecs[i].res;
            #1;
            check($sformatf("vec%0d", i), vecs[i].ph, vecs[i].exp);
            @(negedge clk);
        end

        // STO in ALU_OP, then asynchronous reset between clock edges
        opcode = STO; mem_ready = 1'b1; resume = 1'b0;
        #1;
        check("sto_alu_op", 3'd6, DE);
        rst_n = 1'b0;
        #1;
        check("async_reset", 3'd0, P0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset_no_wr%0d", i), 3'd0, P0);
        end
        rst_n = 1'b1;
        #1;
        check("restart_p0", 3'd0, P0);
        @(negedge clk);
        #1;
        check("restart_p1", 3'd1, P1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
